power_button_debounce: RTL
==========================

Name: power_button_debounce

Overview:
Conditions the raw mechanical power button for power_switch_fsm and for software. It synchronises the pad and debounces press and release edges. It drives the clean level btn_pressed that power_switch_fsm consumes directly. It also emits one-cycle press, short-press and long-press events for the system controller. Sits between the button pad and power_switch_fsm in the always-on clock domain.

Parameters:
CLK_HZ, 0, clk frequency in Hz; valid range 1000..150000000, otherwise elaboration $error.
DEBOUNCE_MS, 20, stable time in ms required to accept a press or a release; valid range 1..1000.
LONG_PRESS_MS, 2000, hold time in ms, measured from the accepted press, for a long-press event; must be greater than DEBOUNCE_MS.
BTN_ACTIVE_LOW, 1, 1 means btn_raw=0 is pressed; 0 means btn_raw=1 is pressed.

Ports:
clk  in  1  always-on system clock.
rst_n  in  1  asynchronous active-low reset.
btn_raw  in  1  raw button pad, asynchronous to clk.
btn_pressed  out  1  debounced level, 1 while the button is held; feeds power_switch_fsm.
btn_press_evt  out  1  one-cycle pulse when a press is accepted.
btn_short_evt  out  1  one-cycle pulse when a release is accepted and no long event fired during that press.
btn_long_evt  out  1  one-cycle pulse once per press when the hold reaches LONG_CYC.

Behaviour:
- Derived constants: DEB_CYC = CLK_HZ/1000*DEBOUNCE_MS; LONG_CYC = CLK_HZ/1000*LONG_PRESS_MS. Both are 32-bit unsigned.
- Reset (asserted rst_n=0, asynchronous):
  - All outputs 0.
  - 2-flop synchroniser loaded with the inactive pad level.
  - deb_cnt=0, hold_cnt=0, long_done=0, state=ST_IDLE.
- Synchroniser: btn_raw passes through 2 flops; act = synchronised value XOR BTN_ACTIVE_LOW. Only act is used downstream.
- ST_IDLE: act=1 -> ST_PRESS_DEB with deb_cnt=0.
- ST_PRESS_DEB:
  - act=0 -> ST_IDLE (bounce rejected, no event).
  - Otherwise deb_cnt++.
  - When deb_cnt==DEB_CYC-1 and act=1 -> ST_PRESSED; btn_pressed<=1; btn_press_evt pulses for 1 cycle; hold_cnt=0; long_done=0.
- ST_PRESSED:
  - hold_cnt increments each cycle and saturates at LONG_CYC.
  - When hold_cnt==LONG_CYC-1 and long_done=0: btn_long_evt pulses for 1 cycle; long_done<=1.
  - act=0 -> ST_RELEASE_DEB with deb_cnt=0.
- ST_RELEASE_DEB:
  - hold_cnt keeps counting here too.
  - act=1 -> ST_PRESSED (release bounce rejected); hold_cnt and long_done are kept.
  - Otherwise deb_cnt++.
  - When deb_cnt==DEB_CYC-1 -> ST_IDLE; btn_pressed<=0; btn_short_evt pulses if long_done=0.
- btn_pressed stays 1 through ST_PRESSED and ST_RELEASE_DEB, and changes only on accepted edges.
- Latency:
  - btn_raw going active to btn_pressed=1 is 2 (sync) + DEB_CYC + 1 cycles, with a stable pad.
  - Release has the same latency.
- Simultaneous events: long and short never pulse in the same cycle. At most one btn_long_evt per accepted press.
- Pad held active through reset release: a press is accepted after normal debounce, so btn_pressed=1 is presented to power_switch_fsm at power-up.
- Illegal state encoding -> ST_IDLE with outputs cleared.
- Event outputs are registered, 1-cycle, and never asserted on consecutive cycles.

Test Plan:
All scenarios use CLK_HZ=1000, DEBOUNCE_MS=20 (DEB_CYC=20), LONG_PRESS_MS=200 (LONG_CYC=200), BTN_ACTIVE_LOW=1.

1. Reset value: btn_raw=0 (pressed) held while rst_n=0 -> all outputs 0. Release rst_n -> btn_pressed=1 and btn_press_evt pulse at cycle 23 after reset release, ±1 cycle.
2. Press bounce: btn_raw pulsed low for 5 cycles, then 10 cycles, each followed by 1 cycle high -> no btn_press_evt; btn_pressed stays 0.
3. Short press: btn_raw low for 100 cycles, then high -> btn_press_evt once. On release, btn_pressed falls ~23 cycles after the rising pad edge, with btn_short_evt in that same cycle. btn_long_evt never fires.
4. Long press: btn_raw low for 500 cycles -> btn_long_evt exactly once, 200 cycles after btn_press_evt. On release, btn_pressed falls and there is no btn_short_evt.
5. Release bounce: while pressed, btn_raw high for 8 cycles then low again -> btn_pressed stays 1, no event, and hold_cnt is not reset (long event timing unchanged).
6. Mid-debounce reset: rst_n pulsed low during ST_RELEASE_DEB -> outputs 0 immediately (asynchronous). The FSM restarts from ST_IDLE and re-accepts the press if the pad is still low.

Source files
------------

// File: rtl/power_button_debounce.sv
// Power button conditioner: pad synchroniser, press/release debounce,
// clean level for power_switch_fsm and press/short/long event pulses.
module power_button_debounce #(
  parameter int unsigned CLK_HZ        = 0,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_PRESS_MS = 2000,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_pressed,
  output logic btn_press_evt,
  output logic btn_short_evt,
  output logic btn_long_evt
);

  localparam logic [31:0] DEB_CYC  = 32'(CLK_HZ / 1000 * DEBOUNCE_MS);
  localparam logic [31:0] LONG_CYC = 32'(CLK_HZ / 1000 * LONG_PRESS_MS);

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_PRESS_DEB   = 2'd1;
  localparam logic [1:0] ST_PRESSED     = 2'd2;
  localparam logic [1:0] ST_RELEASE_DEB = 2'd3;

  if (CLK_HZ < 1000 || CLK_HZ > 150000000) begin : g_bad_clk
    $error("power_button_debounce: CLK_HZ out of range");
  end
  if (DEBOUNCE_MS < 1 || DEBOUNCE_MS > 1000) begin : g_bad_deb
    $error("power_button_debounce: DEBOUNCE_MS out of range");
  end
  if (LONG_PRESS_MS <= DEBOUNCE_MS) begin : g_bad_long
    $error("power_button_debounce: LONG_PRESS_MS must exceed DEBOUNCE_MS");
  end

  logic        s1_q;
  logic        s2_q;
  logic        act;
  logic [1:0]  state_q, state_d;
  logic [31:0] deb_q, deb_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] hold_inc;
  logic        long_done_q, long_done_d;
  logic        pressed_q, pressed_d;
  logic        press_evt_q, press_evt_d;
  logic        short_evt_q, short_evt_d;
  logic        long_evt_q, long_evt_d;

  // act is 1 while the pad is in its pressed level, whatever the polarity
  assign act = s2_q ^ BTN_ACTIVE_LOW;

  assign hold_inc = (hold_q < LONG_CYC) ? hold_q + 32'd1 : hold_q;

  always_comb begin
    state_d     = state_q;
    deb_d       = deb_q;
    hold_d      = hold_q;
    long_done_d = long_done_q;
    pressed_d   = pressed_q;
    press_evt_d = 1'b0;
    short_evt_d = 1'b0;
    long_evt_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (act) begin
          state_d = ST_PRESS_DEB;
          deb_d   = '0;
        end
      end
      ST_PRESS_DEB: begin
        if (!act) begin
          state_d = ST_IDLE;
        end else if (deb_q == DEB_CYC - 32'd1) begin
          state_d     = ST_PRESSED;
          pressed_d   = 1'b1;
          press_evt_d = 1'b1;
          hold_d      = '0;
          long_done_d = 1'b0;
        end else begin
          deb_d = deb_q + 32'd1;
        end
      end
      ST_PRESSED: begin
        hold_d = hold_inc;
        if (hold_q == LONG_CYC - 32'd1 && !long_done_q) begin
          long_evt_d  = 1'b1;
          long_done_d = 1'b1;
        end
        if (!act) begin
          state_d = ST_RELEASE_DEB;
          deb_d   = '0;
        end
      end
      ST_RELEASE_DEB: begin
        // hold time keeps running so a rejected release bounce is invisible
        hold_d = hold_inc;
        if (act) begin
          state_d = ST_PRESSED;
        end else if (deb_q == DEB_CYC - 32'd1) begin
          state_d     = ST_IDLE;
          pressed_d   = 1'b0;
          short_evt_d = !long_done_q;
        end else begin
          deb_d = deb_q + 32'd1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        deb_d       = '0;
        hold_d      = '0;
        long_done_d = 1'b0;
        pressed_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= BTN_ACTIVE_LOW;
      s2_q        <= BTN_ACTIVE_LOW;
      state_q     <= ST_IDLE;
      deb_q       <= '0;
      hold_q      <= '0;
      long_done_q <= 1'b0;
      pressed_q   <= 1'b0;
      press_evt_q <= 1'b0;
      short_evt_q <= 1'b0;
      long_evt_q  <= 1'b0;
    end else begin
      s1_q        <= btn_raw;
      s2_q        <= s1_q;
      state_q     <= state_d;
      deb_q       <= deb_d;
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      pressed_q   <= pressed_d;
      press_evt_q <= press_evt_d;
      short_evt_q <= short_evt_d;
      long_evt_q  <= long_evt_d;
    end
  end

  assign btn_pressed   = pressed_q;
  assign btn_press_evt = press_evt_q;
  assign btn_short_evt = short_evt_q;
  assign btn_long_evt  = long_evt_q;

endmodule
